// File: rtl/dcache_miss_ctrl.sv
// Miss/refill sequencer for the 2-way data-cache group.
// Ports: cpu_* request/response, c_* group controls/status,
//   mem_* line-wide memory port, hit_cnt/miss_cnt statistics.
module dcache_miss_ctrl #(
    parameter int LINE_W = 256,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_byte_en,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_busy,
    output logic              c_enable,
    output logic              c_compare,
    output logic              c_read,
    output logic [31:0]       c_address,
    output logic [31:0]       c_data_in,
    output logic [3:0]        c_byte_w_en,
    output logic [LINE_W-1:0] c_data_line_in,
    input  logic              c_hit,
    input  logic              c_dirty,
    input  logic              c_valid,
    input  logic [31:0]       c_data_out,
    input  logic [31:0]       c_address_out,
    input  logic [LINE_W-1:0] c_data_line_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        PROBE,
        WRITEBACK,
        ALLOCATE,
        FILL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic              req_we;
    logic              retry;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic [LINE_W-1:0] fill_line;

    // Victim line offset bits are always zero; only the line part is used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^c_address_out[4:0];

    assign c_address      = req_addr;
    assign c_data_in      = req_wdata;
    assign c_byte_w_en    = req_be;
    assign c_data_line_in = fill_line;

    always_comb begin
        c_enable  = 1'b0;
        c_compare = 1'b0;
        c_read    = 1'b0;
        case (state)
            COMPARE: begin
                c_enable  = 1'b1;
                c_compare = 1'b1;
                c_read    = !req_we;
            end
            PROBE: begin
                c_enable = 1'b1;
                c_read   = 1'b1;
            end
            FILL: begin
                c_enable = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            req_we    <= 1'b0;
            retry     <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            fill_line <= '0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            cpu_busy  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            cpu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        req_be    <= cpu_we ? cpu_byte_en : 4'b0;
                        retry     <= 1'b0;
                        cpu_busy  <= 1'b1;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (c_hit) begin
                        if (!req_we)
                            cpu_rdata <= c_data_out;
                        // A retry hit is the same request; count it once.
                        if (!retry && hit_cnt != CNT_MAX)
                            hit_cnt <= hit_cnt + CNT_ONE;
                        cpu_done <= 1'b1;
                        cpu_busy <= 1'b0;
                        state    <= IDLE;
                    end else if (retry) begin
                        // Miss right after a fill: drop silently.
                        cpu_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        if (miss_cnt != CNT_MAX)
                            miss_cnt <= miss_cnt + CNT_ONE;
                        state <= PROBE;
                    end
                end
                PROBE: begin
                    mem_req <= 1'b1;
                    if (c_dirty && c_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= {c_address_out[31:5], 5'b0};
                        mem_wdata <= c_data_line_out;
                        state     <= WRITEBACK;
                    end else begin
                        mem_we   <= 1'b0;
                        mem_addr <= {req_addr[31:5], 5'b0};
                        state    <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        // Request drops for one cycle between transfers.
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_addr <= {req_addr[31:5], 5'b0};
                        state    <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_req && mem_ack) begin
                        fill_line <= mem_rdata;
                        mem_req   <= 1'b0;
                        state     <= FILL;
                    end else if (!mem_req) begin
                        mem_req <= 1'b1;
                    end
                end
                FILL: begin
                    retry <= 1'b1;
                    state <= COMPARE;
                end
                default: begin
                    cpu_busy <= 1'b0;
                    mem_req  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Randomized bench for dcache_miss_ctrl with a 2-way group model,
// a line memory responder and a word-level golden memory.
module tb_dcache_miss_ctrl;

    localparam int LW = 256;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [3:0]    cpu_byte_en;
    logic [31:0]   cpu_rdata;
    logic          cpu_done;
    logic          cpu_busy;
    logic          c_enable;
    logic          c_compare;
    logic          c_read;
    logic [31:0]   c_address;
    logic [31:0]   c_data_in;
    logic [3:0]    c_byte_w_en;
    logic [LW-1:0] c_data_line_in;
    logic          c_hit;
    logic          c_dirty;
    logic          c_valid;
    logic [31:0]   c_data_out;
    logic [31:0]   c_address_out;
    logic [LW-1:0] c_data_line_out;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_ack;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    dcache_miss_ctrl #(.LINE_W(LW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_byte_en(cpu_byte_en), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_busy(cpu_busy),
        .c_enable(c_enable), .c_compare(c_compare),
        .c_read(c_read), .c_address(c_address),
        .c_data_in(c_data_in), .c_byte_w_en(c_byte_w_en),
        .c_data_line_in(c_data_line_in), .c_hit(c_hit),
        .c_dirty(c_dirty), .c_valid(c_valid),
        .c_data_out(c_data_out), .c_address_out(c_address_out),
        .c_data_line_out(c_data_line_out),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++)
            l[32*i +: 32] = init_word(la + 32'(4 * i));
        return l;
    endfunction

    // ---------------- 2-way group model (4 sets) ----------------
    logic [LW-1:0] g_data [4][2];
    logic [24:0]   g_tag  [4][2];
    logic          g_val  [4][2];
    logic          g_dty  [4][2];
    logic          g_vp   [4];
    logic          g_fw   [4];
    logic          g_clr;

    logic [1:0]    gs;
    logic          gh_w;
    logic          gh_raw;
    logic          gv_w;
    logic [LW-1:0] g_merged;

    always_comb begin
        gs = c_address[6:5];
        gh_w = 1'b0;
        gh_raw = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (g_val[gs][w] && g_tag[gs][w] == c_address[31:7]) begin
                gh_raw = 1'b1;
                gh_w = (w == 1);
            end
        end
        c_hit = c_enable && c_compare && gh_raw;
        c_data_out = g_data[gs][gh_w][{c_address[4:2], 5'b0} +: 32];
        g_merged = g_data[gs][gh_w];
        for (int b = 0; b < 4; b++)
            if (c_byte_w_en[b])
                g_merged[{c_address[4:2], 5'b0} + 8*b +: 8] =
                    c_data_in[8*b +: 8];
        gv_w = g_vp[gs];
        c_valid = g_val[gs][gv_w];
        c_dirty = g_dty[gs][gv_w];
        c_address_out = {g_tag[gs][gv_w], gs, 5'b0};
        c_data_line_out = g_data[gs][gv_w];
    end

    always @(posedge clk) begin
        if (g_clr) begin
            for (int s = 0; s < 4; s++) begin
                g_vp[s] <= 1'b0;
                g_fw[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    g_val[s][w]  <= 1'b0;
                    g_dty[s][w]  <= 1'b0;
                    g_tag[s][w]  <= '0;
                    g_data[s][w] <= '0;
                end
            end
        end else if (c_enable) begin
            if (c_compare) begin
                if (c_hit && |c_byte_w_en) begin
                    g_data[gs][gh_w] <= g_merged;
                    g_dty[gs][gh_w]  <= 1'b1;
                end
            end else if (c_read) begin
                g_fw[gs] <= g_vp[gs];
                g_vp[gs] <= ~g_vp[gs];
            end else begin
                g_data[gs][g_fw[gs]] <= c_data_line_in;
                g_tag[gs][g_fw[gs]]  <= c_address[31:7];
                g_val[gs][g_fw[gs]]  <= 1'b1;
                g_dty[gs][g_fw[gs]]  <= 1'b0;
            end
        end
    end

    // ---------------- line memory responder ----------------
    logic [255:0] mem_lines [int unsigned];
    int           force_lat;
    int           rsp_cnt;
    int           rsp_lat;
    int           wb_cnt;
    int           rd_cnt;
    int           lat_wb;
    int           lat_rd;
    logic [31:0]  wb_addr;
    logic [31:0]  rd_addr;
    logic [255:0] wb_data;

    function automatic logic [255:0] get_line(input logic [31:0] la);
        if (mem_lines.exists(la))
            return mem_lines[la];
        return init_line(la);
    endfunction

    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        rsp_cnt = -1;
        rsp_lat = 1;
        wb_cnt = 0;
        rd_cnt = 0;
        lat_wb = 0;
        lat_rd = 0;
        wb_addr = '0;
        rd_addr = '0;
        wb_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                rsp_cnt = -1;
            end else if (!mem_req) begin
                rsp_cnt = -1;
            end else begin
                if (rsp_cnt < 0) begin
                    rsp_lat = (force_lat > 0) ? force_lat
                                              : $urandom_range(1, 4);
                    rsp_cnt = rsp_lat - 1;
                end else begin
                    rsp_cnt--;
                end
                if (rsp_cnt == 0) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        wb_cnt++;
                        wb_addr = mem_addr;
                        wb_data = mem_wdata;
                        mem_lines[mem_addr] = mem_wdata;
                        lat_wb = rsp_lat;
                    end else begin
                        rd_cnt++;
                        rd_addr = mem_addr;
                        mem_rdata = get_line(mem_addr);
                        lat_rd = rsp_lat;
                    end
                end
            end
        end
    end

    // ---------------- reference: golden words + counters ----------------
    logic [31:0] gold [int unsigned];
    int          exp_hit;
    int          exp_miss;

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b0};
        if (gold.exists(wa))
            return gold[wa];
        return init_word(wa);
    endfunction

    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be);
        logic [1:0]   s;
        logic         present;
        logic         vw;
        logic         vdirty;
        logic [31:0]  vaddr;
        logic [255:0] vline;
        logic [31:0]  w;
        logic         was_fill;
        int wb0, rd0, cyc, probes, exp_lat;
        bit done;
        s = addr[6:5];
        present = (g_val[s][0] && g_tag[s][0] == addr[31:7]) ||
                  (g_val[s][1] && g_tag[s][1] == addr[31:7]);
        vw = g_vp[s];
        vdirty = g_val[s][vw] && g_dty[s][vw];
        vaddr = {g_tag[s][vw], s, 5'b0};
        vline = g_data[s][vw];
        wb0 = wb_cnt;
        rd0 = rd_cnt;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wd;
        cpu_byte_en = be;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_byte_en = $urandom_range(0, 15);
        cyc = 1;
        chk("cmp_ctrl", {c_enable, c_compare, c_read}, {2'b11, !we});
        chk("cmp_bwe", c_byte_w_en, we ? be : 4'b0);
        chk("busy", cpu_busy, 1'b1);
        probes = 0;
        done = 0;
        was_fill = 1'b0;
        while (!done && cyc < 80) begin
            if (c_enable && !c_compare && c_read)
                probes++;
            if (mem_req)
                chk("en_in_mem", c_enable, 1'b0);
            if (was_fill)
                chk("retry_hit", c_hit, 1'b1);
            was_fill = c_enable && !c_compare && !c_read;
            @(posedge clk);
            #1;
            cyc++;
            if (cpu_done)
                done = 1;
        end
        if (!done) begin
            chk("timeout", 1'b0, 1'b1);
            return;
        end
        if (present) begin
            if (exp_hit < 255) exp_hit++;
            exp_lat = 2;
        end else begin
            if (exp_miss < 255) exp_miss++;
            exp_lat = vdirty ? 6 + lat_wb + lat_rd : 5 + lat_rd;
        end
        chk("latency", cyc, exp_lat);
        chk("probes", probes, present ? 0 : 1);
        chk("wb_count", wb_cnt - wb0, (!present && vdirty) ? 1 : 0);
        chk("rd_count", rd_cnt - rd0, present ? 0 : 1);
        if (!present && vdirty) begin
            chk("wb_addr", wb_addr, vaddr);
            chk("wb_data", wb_data, vline);
        end
        if (!present)
            chk("rd_addr", rd_addr, {addr[31:5], 5'b0});
        if (we) begin
            w = gold_word(addr);
            for (int b = 0; b < 4; b++)
                if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            gold[{addr[31:2], 2'b0}] = w;
        end else begin
            chk("rdata", cpu_rdata, gold_word(addr));
        end
        chk("hit_cnt", hit_cnt, exp_hit[CW-1:0]);
        chk("miss_cnt", miss_cnt, exp_miss[CW-1:0]);
        chk("busy_end", cpu_busy, 1'b0);
        @(posedge clk);
        #1;
        chk("done_pulse", cpu_done, 1'b0);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = '0;
        a[8:7] = 2'($urandom_range(0, 3));
        a[6:5] = 2'($urandom_range(0, 3));
        a[4:2] = 3'($urandom_range(0, 7));
        return a;
    endfunction

    initial begin
        int k;
        logic [31:0] m;
        bit saw_done;
        rst = 1'b0;
        g_clr = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        cpu_byte_en = '0;
        force_lat = 0;
        exp_hit = 0;
        exp_miss = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {cpu_done, cpu_busy, mem_req, mem_we}, 4'b0);
        chk("rst_c", {c_enable, c_compare, c_read}, 3'b0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_cnt", {hit_cnt, miss_cnt}, 16'h0);
        rst = 1'b1;
        g_clr = 1'b0;
        @(posedge clk);
        #1;

        // clean miss with 3-cycle memory, then hit, store merge, reload
        force_lat = 3;
        do_req(1'b0, 32'h0000_0104, 32'h0, 4'h0);
        force_lat = 0;
        do_req(1'b0, 32'h0000_0104, 32'h0, 4'h0);
        do_req(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011);
        do_req(1'b0, 32'h0000_0104, 32'h0, 4'h0);
        m = init_word(32'h104);
        chk("merge", cpu_rdata, {m[31:16], 16'hBEEF});

        // dirty lines in set 0, then conflicting loads force writebacks
        do_req(1'b1, 32'h0000_4000, 32'h1234_ABCD, 4'b1111);
        do_req(1'b0, 32'h0000_6000, 32'h0, 4'h0);
        do_req(1'b0, 32'h0000_8000, 32'h0, 4'h0);
        do_req(1'b0, 32'h0000_4000, 32'h0, 4'h0);
        chk("dirty_refill", cpu_rdata, 32'h1234_ABCD);

        // reset while the refill is outstanding
        force_lat = 10;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 32'h0000_A020;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        k = 0;
        while (!(mem_req && !mem_we) && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("alloc_reached", k < 20, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_mid_busy", cpu_busy, 1'b0);
        chk("rst_mid_req", mem_req, 1'b0);
        chk("rst_mid_cnt", {hit_cnt, miss_cnt}, 16'h0);
        chk("rst_mid_en", c_enable, 1'b0);
        exp_hit = 0;
        exp_miss = 0;
        saw_done = 0;
        repeat (5) begin
            if (cpu_done) saw_done = 1;
            @(posedge clk);
            #1;
        end
        chk("rst_mid_nodone", saw_done, 1'b0);
        force_lat = 0;

        // saturate the hit counter
        do_req(1'b0, 32'h0000_0104, 32'h0, 4'h0);
        for (int i = 0; i < (1 << CW) + 5; i++)
            do_req(1'b0, 32'h0000_0108, 32'h0, 4'h0);
        chk("hit_sat", hit_cnt, 8'hFF);

        // randomized traffic over conflicting lines
        for (int i = 0; i < 200; i++) begin
            logic we;
            we = 1'($urandom_range(0, 1));
            do_req(we, rnd_addr(), $urandom(),
                   4'($urandom_range(1, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
